// File: rtl/time_set_ctrl.sv
// Time/date/alarm setting controller. Button presses edit shadow copies of
// the running time, date and alarm; a completed time/date edit is handed to
// the timekeeping datapath with a one-cycle load strobe.
module time_set_ctrl #(
    parameter int TIMEOUT_TICKS = 10000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        tick,
    input  logic        btn_set,
    input  logic        btn_alarm,
    input  logic        btn_next,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic [17:0] cur_time,
    input  logic [15:0] cur_date,
    input  logic [16:0] cur_alarm,
    output logic        mode,
    output logic        mode_state,
    output logic        setting,
    output logic [17:0] set_time,
    output logic [15:0] set_date,
    output logic [16:0] set_alarm,
    output logic [2:0]  field
);

    typedef enum logic [1:0] {IDLE, EDIT_TD, EDIT_AL, COMMIT} state_t;

    localparam logic [2:0] FIELD_HOUR  = 3'd0;
    localparam logic [2:0] FIELD_MIN   = 3'd1;
    localparam logic [2:0] FIELD_SEC   = 3'd2;
    localparam logic [2:0] FIELD_YEAR  = 3'd3;
    localparam logic [2:0] FIELD_MONTH = 3'd4;
    localparam logic [2:0] FIELD_DAY   = 3'd5;
    localparam logic [2:0] FIELD_NONE  = 3'd7;

    localparam int               CNT_W    = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_TICKS - 1);

    // Step a field by one inside [lo, hi], wrapping at both ends.
    function automatic logic [6:0] wrap_step(input logic [6:0] value, input logic [6:0] lo,
                                             input logic [6:0] hi, input logic up);
        logic [6:0] res;
        if (up) res = (value >= hi) ? lo : value + 7'd1;
        else    res = (value <= lo) ? hi : value - 7'd1;
        return res;
    endfunction

    // Days in month; leap years are the years divisible by four (00..99).
    function automatic logic [4:0] days_in_month(input logic [3:0] month, input logic [6:0] year);
        logic [4:0] dim;
        case (month)
            4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
            4'd2:                    dim = (year[1:0] == 2'b00) ? 5'd29 : 5'd28;
            default:                 dim = 5'd31;
        endcase
        return dim;
    endfunction

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [2:0]       field_nx;
    logic             mode_nx, mode_state_nx, setting_nx;
    logic [17:0]      set_time_nx;
    logic [15:0]      set_date_nx;
    logic [16:0]      set_alarm_nx;
    logic             step_en, any_btn;
    logic [6:0]       val;
    logic [4:0]       dim;

    // Next state, field edits, inactivity timeout and next output values.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can infer a latch.
        state_nx     = state;
        cnt_nx       = cnt;
        field_nx     = field;
        set_time_nx  = set_time;
        set_date_nx  = set_date;
        set_alarm_nx = set_alarm;
        val          = '0;
        dim          = '0;
        step_en      = btn_up ^ btn_down;   // both at once cancel out
        any_btn      = btn_set | btn_alarm | btn_next | btn_up | btn_down;

        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (btn_set) begin
                    state_nx    = EDIT_TD;
                    field_nx    = FIELD_HOUR;
                    set_time_nx = cur_time;
                    set_date_nx = cur_date;
                end else if (btn_alarm) begin
                    state_nx     = EDIT_AL;
                    field_nx     = FIELD_HOUR;
                    set_alarm_nx = cur_alarm;
                end
            end
            EDIT_TD, EDIT_AL: begin
                if (btn_set || btn_alarm) begin
                    state_nx = IDLE;                  // cancel, no load strobe
                end else if (btn_next) begin
                    if (state == EDIT_TD && field == FIELD_DAY)      state_nx = COMMIT;
                    else if (state == EDIT_AL && field == FIELD_SEC) state_nx = IDLE;
                    else                                             field_nx = field + 3'd1;
                end else if (step_en) begin
                    if (state == EDIT_AL) begin
                        case (field)
                            FIELD_HOUR: begin
                                val = wrap_step({2'b0, set_alarm[16:12]}, 7'd0, 7'd23, btn_up);
                                set_alarm_nx[16:12] = val[4:0];
                            end
                            FIELD_MIN: begin
                                val = wrap_step({1'b0, set_alarm[11:6]}, 7'd0, 7'd59, btn_up);
                                set_alarm_nx[11:6] = val[5:0];
                            end
                            default: begin
                                val = wrap_step({1'b0, set_alarm[5:0]}, 7'd0, 7'd59, btn_up);
                                set_alarm_nx[5:0] = val[5:0];
                            end
                        endcase
                    end else begin
                        case (field)
                            FIELD_HOUR: begin
                                val = wrap_step({2'b0, set_time[16:12]}, 7'd0, 7'd23, btn_up);
                                set_time_nx[16:12] = val[4:0];
                                set_time_nx[17]    = (val >= 7'd12);   // meridian tracks hour
                            end
                            FIELD_MIN: begin
                                val = wrap_step({1'b0, set_time[11:6]}, 7'd0, 7'd59, btn_up);
                                set_time_nx[11:6] = val[5:0];
                            end
                            FIELD_SEC: begin
                                val = wrap_step({1'b0, set_time[5:0]}, 7'd0, 7'd59, btn_up);
                                set_time_nx[5:0] = val[5:0];
                            end
                            FIELD_YEAR: begin
                                val = wrap_step(set_date[15:9], 7'd0, 7'd99, btn_up);
                                dim = days_in_month(set_date[8:5], val);
                                set_date_nx[15:9] = val;
                                if (set_date[4:0] > dim) set_date_nx[4:0] = dim;
                            end
                            FIELD_MONTH: begin
                                val = wrap_step({3'b0, set_date[8:5]}, 7'd1, 7'd12, btn_up);
                                dim = days_in_month(val[3:0], set_date[15:9]);
                                set_date_nx[8:5] = val[3:0];
                                if (set_date[4:0] > dim) set_date_nx[4:0] = dim;
                            end
                            default: begin
                                dim = days_in_month(set_date[8:5], set_date[15:9]);
                                val = wrap_step({2'b0, set_date[4:0]}, 7'd1, {2'b0, dim}, btn_up);
                                set_date_nx[4:0] = val[4:0];
                            end
                        endcase
                    end
                end else if (tick) begin
                    if (cnt == CNT_LAST) state_nx = IDLE;   // abandoned edit
                    else                 cnt_nx   = cnt + CNT_W'(1);
                end
                if (any_btn) cnt_nx = '0;
            end
            default: state_nx = IDLE;                     // COMMIT lasts one cycle, buttons ignored
        endcase

        if (state_nx == IDLE) begin
            field_nx = FIELD_NONE;
            cnt_nx   = '0;
        end
        mode_nx       = (state_nx != IDLE);
        mode_state_nx = (state_nx == EDIT_AL);
        setting_nx    = (state_nx == COMMIT);
    end

    // State register, registered outputs and edit shadow registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            cnt        <= '0;
            field      <= FIELD_NONE;
            mode       <= 1'b0;
            mode_state <= 1'b0;
            setting    <= 1'b0;
            set_time   <= '0;
            set_date   <= {7'd16, 4'd1, 5'd1};
            set_alarm  <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state      <= state_nx;
            cnt        <= cnt_nx;
            field      <= field_nx;
            mode       <= mode_nx;
            mode_state <= mode_state_nx;
            setting    <= setting_nx;
            set_time   <= set_time_nx;
            set_date   <= set_date_nx;
            set_alarm  <= set_alarm_nx;
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: directed scenarios plus random
// button traffic, compared every cycle against an integer reference model.
module tb_time_set_ctrl;

    localparam int TIMEOUT = 5;
    localparam int S_IDLE = 0, S_TD = 1, S_AL = 2, S_COMMIT = 3;

    logic        clk = 1'b0;
    logic        resetn;
    logic        tick = 1'b0;
    logic        btn_set = 1'b0, btn_alarm = 1'b0, btn_next = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic [17:0] cur_time = '0;
    logic [15:0] cur_date = '0;
    logic [16:0] cur_alarm = '0;
    logic        mode, mode_state, setting;
    logic [17:0] set_time;
    logic [15:0] set_date;
    logic [16:0] set_alarm;
    logic [2:0]  field;

    time_set_ctrl #(.TIMEOUT_TICKS(TIMEOUT)) dut (
        .clk(clk), .resetn(resetn), .tick(tick),
        .btn_set(btn_set), .btn_alarm(btn_alarm), .btn_next(btn_next),
        .btn_up(btn_up), .btn_down(btn_down),
        .cur_time(cur_time), .cur_date(cur_date), .cur_alarm(cur_alarm),
        .mode(mode), .mode_state(mode_state), .setting(setting),
        .set_time(set_time), .set_date(set_date), .set_alarm(set_alarm),
        .field(field)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int setting_seen = 0;

    // Reference model: plain integers per calendar field.
    int m_st, m_field, m_quiet;
    int t_mer, t_h, t_m, t_s, d_y, d_mo, d_d, a_h, a_m, a_s;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int wrap(int v, int lo, int hi, int delta);
        int n = hi - lo + 1;
        return lo + ((v - lo + delta + n) % n);
    endfunction

    function automatic int dim_of(int mo, int y);
        if (mo == 2) return (y % 4 == 0) ? 29 : 28;
        if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
        return 31;
    endfunction

    task automatic model_reset();
        m_st = S_IDLE; m_field = 0; m_quiet = 0;
        t_mer = 0; t_h = 0; t_m = 0; t_s = 0;
        d_y = 16; d_mo = 1; d_d = 1;
        a_h = 0; a_m = 0; a_s = 0;
    endtask

    task automatic model_step(input logic s, input logic a, input logic n,
                              input logic u, input logic d, input logic t);
        int delta;
        delta = u ? 1 : -1;
        case (m_st)
            S_IDLE: begin
                if (s) begin
                    t_mer = int'(cur_time[17]); t_h = int'(cur_time[16:12]);
                    t_m = int'(cur_time[11:6]); t_s = int'(cur_time[5:0]);
                    d_y = int'(cur_date[15:9]); d_mo = int'(cur_date[8:5]); d_d = int'(cur_date[4:0]);
                    m_st = S_TD; m_field = 0; m_quiet = 0;
                end else if (a) begin
                    a_h = int'(cur_alarm[16:12]); a_m = int'(cur_alarm[11:6]); a_s = int'(cur_alarm[5:0]);
                    m_st = S_AL; m_field = 0; m_quiet = 0;
                end
            end
            S_TD, S_AL: begin
                if (s || a) m_st = S_IDLE;
                else if (n) begin
                    if (m_st == S_TD && m_field == 5)      m_st = S_COMMIT;
                    else if (m_st == S_AL && m_field == 2) m_st = S_IDLE;
                    else                                   m_field++;
                end else if (u != d) begin
                    if (m_st == S_AL) begin
                        if (m_field == 0)      a_h = wrap(a_h, 0, 23, delta);
                        else if (m_field == 1) a_m = wrap(a_m, 0, 59, delta);
                        else                   a_s = wrap(a_s, 0, 59, delta);
                    end else begin
                        case (m_field)
                            0: begin t_h = wrap(t_h, 0, 23, delta); t_mer = (t_h >= 12) ? 1 : 0; end
                            1: t_m = wrap(t_m, 0, 59, delta);
                            2: t_s = wrap(t_s, 0, 59, delta);
                            3: begin d_y = wrap(d_y, 0, 99, delta); if (d_d > dim_of(d_mo, d_y)) d_d = dim_of(d_mo, d_y); end
                            4: begin d_mo = wrap(d_mo, 1, 12, delta); if (d_d > dim_of(d_mo, d_y)) d_d = dim_of(d_mo, d_y); end
                            default: d_d = wrap(d_d, 1, dim_of(d_mo, d_y), delta);
                        endcase
                    end
                end else if (t) begin
                    m_quiet++;
                    if (m_quiet >= TIMEOUT) m_st = S_IDLE;
                end
                if (s || a || n || u || d) m_quiet = 0;
            end
            default: m_st = S_IDLE;
        endcase
    endtask

    task automatic compare_all(input string pfx);
        check({pfx, "_mode"}, 32'(mode), (m_st != S_IDLE) ? 1 : 0);
        check({pfx, "_mode_state"}, 32'(mode_state), (m_st == S_AL) ? 1 : 0);
        check({pfx, "_setting"}, 32'(setting), (m_st == S_COMMIT) ? 1 : 0);
        if (m_st != S_COMMIT)
            check({pfx, "_field"}, 32'(field), (m_st == S_IDLE) ? 7 : m_field);
        check({pfx, "_set_time"}, 32'(set_time), t_mer * 131072 + t_h * 4096 + t_m * 64 + t_s);
        check({pfx, "_set_date"}, 32'(set_date), d_y * 512 + d_mo * 32 + d_d);
        check({pfx, "_set_alarm"}, 32'(set_alarm), a_h * 4096 + a_m * 64 + a_s);
    endtask

    // One clock cycle: called at a falling edge, returns at the next one.
    task automatic step(input logic s, input logic a, input logic n,
                        input logic u, input logic d, input logic t);
        btn_set = s; btn_alarm = a; btn_next = n; btn_up = u; btn_down = d; tick = t;
        @(posedge clk);
        model_step(s, a, n, u, d, t);
        #1;
        compare_all("cyc");
        if (setting === 1'b1) setting_seen++;
        btn_set = 0; btn_alarm = 0; btn_next = 0; btn_up = 0; btn_down = 0; tick = 0;
        @(negedge clk);
    endtask

    task automatic randomize_cur();
        int h, mo, y;
        h = $urandom_range(0, 23); mo = $urandom_range(1, 12); y = $urandom_range(0, 99);
        cur_time  = {(h >= 12) ? 1'b1 : 1'b0, 5'(h), 6'($urandom_range(0, 59)), 6'($urandom_range(0, 59))};
        cur_date  = {7'(y), 4'(mo), 5'($urandom_range(1, dim_of(mo, y)))};
        cur_alarm = {5'($urandom_range(0, 23)), 6'($urandom_range(0, 59)), 6'($urandom_range(0, 59))};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic s, a, n, u, d, t;
        int r;
        resetn = 1'b0;
        model_reset();
        cur_time = {1'b0, 5'd11, 6'd59, 6'd30};
        cur_date = {7'd16, 4'd3, 5'd31};
        repeat (2) @(negedge clk);
        compare_all("reset");
        resetn = 1'b1;

        // Button accepted on first edge after reset; 11:59:30 -> 12, then commit.
        step(1, 0, 0, 0, 0, 0);
        check("r031_mode", 32'(mode), 1);
        step(0, 0, 0, 1, 0, 0);
        check("r032_hour", 32'(set_time[16:12]), 12);
        check("r032_meridian", 32'(set_time[17]), 1);
        setting_seen = 0;
        repeat (6) step(0, 0, 1, 0, 0, 0);
        check("r032_commit", 32'(setting), 1);
        step(0, 0, 0, 0, 0, 0);
        check("r032_idle", 32'(mode), 0);
        check("r032_pulses", 32'(setting_seen), 1);

        // Wrap boundaries for hour, minute and month; cancel keeps edits.
        cur_time = {1'b0, 5'd0, 6'd59, 6'd30};
        cur_date = {7'd20, 4'd12, 5'd15};
        setting_seen = 0;
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        check("r033_hour_wrap", 32'(set_time[16:12]), 23);
        check("r033_meridian", 32'(set_time[17]), 1);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        check("r033_min_wrap", 32'(set_time[11:6]), 0);
        repeat (3) step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        check("r033_month_wrap", 32'(set_date[8:5]), 1);
        step(1, 0, 0, 0, 0, 0);
        check("r025_abort_mode", 32'(mode), 0);
        check("r025_kept_month", 32'(set_date[8:5]), 1);
        check("r025_no_setting", 32'(setting_seen), 0);

        // Day clamp on month change, leap and non-leap.
        cur_date = {7'd16, 4'd3, 5'd31};
        step(1, 0, 0, 0, 0, 0);
        repeat (4) step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        check("r034_month", 32'(set_date[8:5]), 2);
        check("r034_day_leap", 32'(set_date[4:0]), 29);
        step(0, 1, 0, 0, 0, 0);
        cur_date = {7'd17, 4'd3, 5'd31};
        step(1, 0, 0, 0, 0, 0);
        repeat (4) step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        check("r034_day_plain", 32'(set_date[4:0]), 28);
        step(1, 0, 0, 0, 0, 0);

        // Alarm edit: hour +2, three NEXT back to idle, no load strobe.
        cur_alarm = {5'd7, 6'd30, 6'd0};
        setting_seen = 0;
        step(0, 1, 0, 0, 0, 0);
        check("r035_ms_enter", 32'(mode_state), 1);
        repeat (2) begin
            step(0, 0, 0, 1, 0, 0);
            check("r035_ms_up", 32'(mode_state), 1);
        end
        repeat (2) begin
            step(0, 0, 1, 0, 0, 0);
            check("r035_ms_next", 32'(mode_state), 1);
        end
        step(0, 0, 1, 0, 0, 0);
        check("r035_idle", 32'(mode), 0);
        check("r035_alarm_hour", 32'(set_alarm[16:12]), 9);
        check("r035_no_setting", 32'(setting_seen), 0);

        // Inactivity timeout after five ticks, then NEXT beats UP.
        setting_seen = 0;
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 1);
        check("r036_before_timeout", 32'(mode), 1);
        step(0, 0, 0, 0, 0, 1);
        check("r036_timeout", 32'(mode), 0);
        check("r036_no_setting", 32'(setting_seen), 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        check("r036_field", 32'(field), 1);
        check("r036_hour_kept", 32'(set_time[16:12]), 32'(cur_time[16:12]));
        step(1, 0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of COMMIT.
        step(1, 0, 0, 0, 0, 0);
        repeat (6) step(0, 0, 1, 0, 0, 0);
        check("r037_in_commit", 32'(setting), 1);
        #1 resetn = 1'b0;
        model_reset();
        #1;
        check("r037_setting", 32'(setting), 0);
        check("r037_date", 32'(set_date), 32'h2021);
        compare_all("r037");
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            randomize_cur();
            r = $urandom_range(0, 99);
            s = 0; a = 0; n = 0; u = 0; d = 0;
            if (m_st == S_IDLE) begin
                if (r < 15)      s = 1;
                else if (r < 25) a = 1;
            end else begin
                if (r < 2)       s = 1;
                else if (r < 3)  a = 1;
                else if (r < 20) n = 1;
                else if (r < 42) u = 1;
                else if (r < 62) d = 1;
                else if (r < 65) begin u = 1; d = 1; end
                else if (r < 68) begin n = 1; u = 1; end
            end
            t = ($urandom_range(0, 3) == 0);
            step(s, a, n, u, d, t);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter TIMEOUT_TICKS, default 10000, TICK pulses of button inactivity before an edit is abandoned.
REQ-002 CLK  in  1  single system clock, all state on rising edge.
REQ-003 RESETN  in  1  asynchronous, active-low reset.
REQ-004 TICK  in  1  one-CLK pulse at 1 kHz, timeout time base.
REQ-005 BTN_SET, BTN_ALARM, BTN_NEXT, BTN_UP, BTN_DOWN  in  1 each  debounced one-CLK press pulses.
REQ-006 CUR_TIME  in  18  running time {MERIDIAN, HOUR[4:0], MIN[5:0], SEC[5:0]}.
REQ-007 CUR_DATE  in  16  running date {YEAR[6:0], MONTH[3:0], DAY[4:0]}.
REQ-008 CUR_ALARM  in  17  stored alarm {HOUR, MIN, SEC}.
REQ-009 MODE  out  1  1 = time datapath frozen and driven from SET_* buses.
REQ-010 MODE_STATE  out  1  0 = time/date editing, 1 = alarm editing.
REQ-011 SETTING  out  1  one-CLK load strobe for SET_TIME/SET_DATE.
REQ-012 SET_TIME  out  18, SET_DATE  out  16, SET_ALARM  out  17  edit shadow registers, same packing as CUR_*.
REQ-013 FIELD  out  3  field under edit (0..5), for display blinking; 7 when idle.

Function
REQ-014 States SHALL be IDLE, EDIT_TD, EDIT_AL, COMMIT.
REQ-015 IDLE: MODE=0, MODE_STATE=0, SETTING=0, FIELD=7.
REQ-016 IDLE + BTN_SET SHALL copy CUR_TIME/CUR_DATE into SET_TIME/SET_DATE, go EDIT_TD, FIELD=0; next cycle MODE=1, MODE_STATE=0.
REQ-017 IDLE + BTN_ALARM SHALL copy CUR_ALARM into SET_ALARM, go EDIT_AL, FIELD=0; MODE=1, MODE_STATE=1.
REQ-018 EDIT_TD fields: 0 HOUR, 1 MIN, 2 SEC, 3 YEAR, 4 MONTH, 5 DAY; EDIT_AL fields: 0 HOUR, 1 MIN, 2 SEC.
REQ-019 BTN_NEXT SHALL advance FIELD by 1; from FIELD 5 in EDIT_TD go COMMIT; from FIELD 2 in EDIT_AL go IDLE keeping SET_ALARM (alarm is latched downstream while MODE=1, MODE_STATE=1).
REQ-020 BTN_UP/BTN_DOWN SHALL increment/decrement the selected field by 1 with wrap: HOUR 0..23, MIN/SEC 0..59, YEAR 0..99, MONTH 1..12, DAY 1..DIM.
REQ-021 DIM = 31 default; 30 for months 4,6,9,11; 29 for month 2 when YEAR[1:0]==0, else 28.
REQ-022 A YEAR or MONTH change that makes DAY > DIM SHALL clamp DAY to DIM in the same cycle.
REQ-023 MERIDIAN bit of SET_TIME SHALL equal (HOUR >= 12), updated with every HOUR change.
REQ-024 Simultaneous buttons priority: BTN_SET/BTN_ALARM (cancel) > BTN_NEXT > BTN_UP/BTN_DOWN; BTN_UP with BTN_DOWN SHALL be ignored.
REQ-025 BTN_SET or BTN_ALARM during EDIT_TD/EDIT_AL SHALL abort to IDLE with no SETTING pulse; SET_* retain edited values.
REQ-026 COMMIT SHALL last exactly one CLK: SETTING=1, MODE=1, MODE_STATE=0, SET_* stable; then IDLE.
REQ-027 Inactivity counter SHALL clear on any button press and on entering an edit state, count TICK pulses, and at TIMEOUT_TICKS abort to IDLE as REQ-025.
REQ-028 Buttons during COMMIT SHALL be ignored.
REQ-029 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-030 RESETN low SHALL immediately force IDLE, MODE=0, MODE_STATE=0, SETTING=0, FIELD=7, SET_TIME=0, SET_DATE={16,1,1}, SET_ALARM=0, timeout counter 0, including mid-edit and mid-COMMIT.
REQ-031 After RESETN rises, first button acceptance SHALL be on the first CLK edge.

Verification
REQ-032 CUR_TIME=11:59:30, BTN_SET, BTN_UP on HOUR -> SET_TIME HOUR=12, MERIDIAN=1; six BTN_NEXT -> one SETTING pulse, then MODE=0.
REQ-033 Edit MIN=59, BTN_UP -> MIN=0; HOUR=0, BTN_DOWN -> HOUR=23; MONTH=12, BTN_UP -> MONTH=1.
REQ-034 DATE 2016-03-31, FIELD=4, BTN_DOWN -> MONTH=2, DAY=29; YEAR=17 same step -> DAY=28.
REQ-035 BTN_ALARM, BTN_UP x2 on HOUR, BTN_NEXT x3 -> MODE_STATE=1 throughout, SET_ALARM HOUR +2, IDLE, SETTING never asserted.
REQ-036 TIMEOUT_TICKS=5, enter edit, 5 TICK pulses, no buttons -> IDLE, no SETTING; BTN_NEXT with BTN_UP same cycle -> field advances, value unchanged.
REQ-037 RESETN low during COMMIT -> SETTING=0 immediately, all outputs at REQ-030 values.
